hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It resolves conditional branches from the EX/MEM stage outputs and redirects the PC. It drives the Flush and hold inputs of IF/ID, ID/EX, EX/MEM and MEM/WB, inserts one bubble on a load-use hazard, and optionally freezes the pipeline while a variable-latency data memory is busy. Saturating event counters give performance visibility.

---
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: branch redirect, load-use bubble, memory-wait freeze.
// Optional variable-latency memory stall enabled by defining HAZARD_CTRL_MEM_WAIT_EN.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_is_greater,
  input  logic [3:0]       mem_funct,
  input  logic             mem_mem_read,
  input  logic             mem_mem_write,
  input  logic             mem_ready,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             cnt_clr,
  output logic             pc_src,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             busy,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e state_q, state_d;
  logic   take_c, lu_c, mw_c, ready_c;
  logic   bubble_inc_c, flush_inc_c, wait_inc_c;
  logic   unused_c;

`ifdef HAZARD_CTRL_MEM_WAIT_EN
  assign mw_c     = (mem_mem_read | mem_mem_write) & ~mem_ready;
  assign ready_c  = mem_ready;
  assign busy     = (state_q == MEM_WAIT);
  assign unused_c = mem_funct[3];
`else
  assign mw_c     = 1'b0;
  assign ready_c  = 1'b1;
  assign busy     = 1'b0;
  assign unused_c = ^{mem_funct[3], mem_mem_read, mem_mem_write, mem_ready, wait_inc_c};
`endif

  // Branch resolution from the EX/MEM compare flags
  always_comb begin
    take_c = 1'b0;
    if (mem_branch) begin
      case (mem_funct[2:0])
        3'b000:  take_c = mem_zero;
        3'b001:  take_c = ~mem_zero;
        3'b100:  take_c = ~mem_zero & ~mem_is_greater;
        3'b101:  take_c = mem_zero | mem_is_greater;
        default: take_c = 1'b0;
      endcase
    end
  end

  assign lu_c = id_ex_mem_read & (id_ex_rd != 5'd0) &
                ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Priority: memory wait, then taken branch, then load-use bubble
  always_comb begin
    state_d      = state_q;
    pc_src       = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    bubble_inc_c = 1'b0;
    flush_inc_c  = 1'b0;
    wait_inc_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (mw_c) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_flush = 1'b1;
          wait_inc_c   = 1'b1;
          state_d      = MEM_WAIT;
        end else if (take_c) begin
          pc_src       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc_c  = 1'b1;
        end else if (lu_c) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_flush  = 1'b1;
          bubble_inc_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!ready_c) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_flush = 1'b1;
          wait_inc_c   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Reset flushes every stage and keeps all registers loading
    if (reset) begin
      pc_src       = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      bubble_inc_c = 1'b0;
      flush_inc_c  = 1'b0;
      wait_inc_c   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     bubble_cnt <= '0;
    else if (cnt_clr)                              bubble_cnt <= '0;
    else if (bubble_inc_c && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   flush_cnt <= '0;
    else if (cnt_clr)                            flush_cnt <= '0;
    else if (flush_inc_c && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
  end

`ifdef HAZARD_CTRL_MEM_WAIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 wait_cnt <= '0;
    else if (cnt_clr)                          wait_cnt <= '0;
    else if (wait_inc_c && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign wait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: action-table model checked every negedge plus literal pins.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_MEM_WAIT_EN
  localparam bit MW_EN = 1'b1;
`else
  localparam bit MW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_branch, mem_zero, mem_is_greater;
  logic [3:0] mem_funct;
  logic       mem_mem_read, mem_mem_write, mem_ready;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       cnt_clr;

  logic        pc_src, pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, busy;
  logic [15:0] bubble_cnt, flush_cnt, wait_cnt;

  logic        s_pc_src, s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write;
  logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_busy;
  logic [1:0]  s_bubble_cnt, s_flush_cnt, s_wait_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_is_greater(mem_is_greater), .mem_funct(mem_funct), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_ready(mem_ready), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .cnt_clr(cnt_clr),
    .pc_src(pc_src), .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .busy(busy),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_is_greater(mem_is_greater), .mem_funct(mem_funct), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_ready(mem_ready), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .cnt_clr(cnt_clr),
    .pc_src(s_pc_src), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .id_ex_write(s_id_ex_write), .ex_mem_write(s_ex_mem_write), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
    .busy(s_busy), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt), .wait_cnt(s_wait_cnt)
  );

  logic [8:0] d_ctrl, s_ctrl;
  assign d_ctrl = {pc_src, pc_write, if_id_write, id_ex_write, ex_mem_write,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  assign s_ctrl = {s_pc_src, s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write,
                   s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush};

  // Model: what the pipeline must do this cycle, and event tallies per counter width
  typedef enum int {A_NONE, A_STALL, A_REDIRECT, A_BUBBLE, A_RESET} act_e;
  bit   m_waiting = 1'b0;
  int   m_bub = 0, m_fl = 0, m_wt = 0;
  int   s_bub = 0, s_fl = 0, s_wt = 0;
  act_e m_act, c_act;

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic bit taken();
    if (!mem_branch) return 1'b0;
    case (mem_funct[2:0])
      3'd0: return mem_zero;
      3'd1: return !mem_zero;
      3'd4: return !mem_zero && !mem_is_greater;
      3'd5: return mem_zero || mem_is_greater;
      default: return 1'b0;
    endcase
  endfunction

  function automatic act_e act_now();
    if (reset) return A_RESET;
    if (m_waiting) return mem_ready ? A_NONE : A_STALL;
    if (MW_EN && (mem_mem_read || mem_mem_write) && !mem_ready) return A_STALL;
    if (taken()) return A_REDIRECT;
    if (id_ex_mem_read && id_ex_rd != 0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2))
      return A_BUBBLE;
    return A_NONE;
  endfunction

  // {pc_src, 4 writes (pc,if_id,id_ex,ex_mem), 4 flushes (if_id,id_ex,ex_mem,mem_wb)}
  function automatic logic [8:0] exp_ctrl(input act_e a);
    case (a)
      A_STALL:    return 9'b0_0000_0001;
      A_REDIRECT: return 9'b1_1111_1110;
      A_BUBBLE:   return 9'b0_0011_0100;
      A_RESET:    return 9'b0_1111_1111;
      default:    return 9'b0_1111_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_waiting = 1'b0;
      m_bub = 0; m_fl = 0; m_wt = 0; s_bub = 0; s_fl = 0; s_wt = 0;
    end else begin
      m_act = act_now();
      case (m_act)
        A_STALL: begin
          m_waiting = 1'b1;
          m_wt = sat(m_wt, 65535); s_wt = sat(s_wt, 3);
        end
        A_NONE:     m_waiting = 1'b0;
        A_REDIRECT: begin m_fl = sat(m_fl, 65535); s_fl = sat(s_fl, 3); end
        A_BUBBLE:   begin m_bub = sat(m_bub, 65535); s_bub = sat(s_bub, 3); end
        default: ;
      endcase
      if (cnt_clr) begin
        m_bub = 0; m_fl = 0; m_wt = 0; s_bub = 0; s_fl = 0; s_wt = 0;
      end
    end
  end

  always @(negedge clk) begin
    c_act = act_now();
    check("ctrl", 32'(d_ctrl), 32'(exp_ctrl(c_act)));
    check("ctrl_w2", 32'(s_ctrl), 32'(exp_ctrl(c_act)));
    check("busy", 32'(busy), 32'(m_waiting && !reset));
    check("busy_w2", 32'(s_busy), 32'(m_waiting && !reset));
    check("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
    check("flush_cnt", 32'(flush_cnt), 32'(m_fl));
    check("wait_cnt", 32'(wait_cnt), 32'(m_wt));
    check("bubble_cnt_w2", 32'(s_bubble_cnt), 32'(s_bub));
    check("flush_cnt_w2", 32'(s_flush_cnt), 32'(s_fl));
    check("wait_cnt_w2", 32'(s_wait_cnt), 32'(s_wt));
  end

  task automatic idle();
    mem_branch = 0; mem_zero = 0; mem_is_greater = 0; mem_funct = 4'd0;
    mem_mem_read = 0; mem_mem_write = 0; mem_ready = 1;
    id_ex_mem_read = 0; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; cnt_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [2:0] f3, input logic z, input logic g);
    idle();
    mem_branch = 1; mem_funct = {1'b0, f3}; mem_zero = z; mem_is_greater = g;
  endtask

  task automatic load_use();
    idle();
    id_ex_mem_read = 1; id_ex_rd = 5'd5; if_id_rs1 = 5'd3; if_id_rs2 = 5'd5;
  endtask

  initial begin
    idle();
    #1 reset = 1;
    #2;
    check("rst_ctrl", 32'(d_ctrl), 32'h0FF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bubble", 32'(bubble_cnt), 32'd0);
    step(); step();
    reset = 0;

    load_use(); #1;
    check("lu_ctrl", 32'(d_ctrl), 32'h034);
    step();
    check("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);

    load_use(); id_ex_rd = 5'd0; if_id_rs2 = 5'd0; #1;
    check("lu_x0_pc_write", 32'(pc_write), 32'd1);
    step();
    check("lu_x0_bubble_cnt", 32'(bubble_cnt), 32'd1);

    branch(3'd0, 1'b1, 1'b0); #1;
    check("beq_ctrl", 32'(d_ctrl), 32'h1FE);
    step();
    check("beq_flush_cnt", 32'(flush_cnt), 32'd1);

    branch(3'd1, 1'b1, 1'b0); #1;
    check("bne_pc_src", 32'(pc_src), 32'd0);
    step();
    check("bne_flush_cnt", 32'(flush_cnt), 32'd1);

    branch(3'd4, 1'b0, 1'b0); step();
    check("blt_flush_cnt", 32'(flush_cnt), 32'd2);
    branch(3'd5, 1'b0, 1'b1); step();
    check("bge_flush_cnt", 32'(flush_cnt), 32'd3);
    branch(3'd6, 1'b0, 1'b0); step();
    check("bltu_not_taken", 32'(flush_cnt), 32'd3);

    load_use(); mem_branch = 1; mem_funct = 4'd0; mem_zero = 1; #1;
    check("take_lu_ctrl", 32'(d_ctrl), 32'h1FE);
    step();
    check("take_lu_flush", 32'(flush_cnt), 32'd4);
    check("take_lu_bubble", 32'(bubble_cnt), 32'd1);

    idle(); mem_mem_read = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1; #1;
    check("mw_ready_busy", 32'(busy), 32'(MW_EN));
    check("mw_ready_pc_write", 32'(pc_write), 32'd1);
    step();
    idle(); #1;
    check("mw_wait_cnt", 32'(wait_cnt), MW_EN ? 32'd3 : 32'd0);
    check("mw_done_busy", 32'(busy), 32'd0);

    idle(); mem_mem_write = 1; mem_ready = 1; step();
    check("mw_zero_lat", 32'(wait_cnt), MW_EN ? 32'd3 : 32'd0);

    load_use(); cnt_clr = 1; step();
    check("clr_bubble", 32'(bubble_cnt), 32'd0);
    check("clr_flush", 32'(flush_cnt), 32'd0);
    check("clr_bubble_w2", 32'(s_bubble_cnt), 32'd0);

    load_use();
    repeat (5) step();
    check("sat_bubble_w16", 32'(bubble_cnt), 32'd5);
    check("sat_bubble_w2", 32'(s_bubble_cnt), 32'd3);

    idle(); mem_mem_read = 1; mem_ready = 0;
    step(); step();
    reset = 1; #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ctrl", 32'(d_ctrl), 32'h0FF);
    check("rst_mid_bubble", 32'(bubble_cnt), 32'd0);
    check("rst_mid_wait", 32'(wait_cnt), 32'd0);
    step();
    reset = 0; idle(); #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ctrl", 32'(d_ctrl), 32'h0F0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
